// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types and constants for the SPI register bridge
package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_RD_TURN = 2'd2,
        ST_RD_DATA = 2'd3
    } state_e;

    localparam int CMD_RD_BIT = 7;
    localparam int ADDR_W     = 7;

    localparam logic [7:0] DEF_STATUS_BYTE = 8'hA5;
    localparam logic [7:0] DEF_IDLE_FILL   = 8'hFF;

    // Register addresses wrap 7'h7F -> 7'h00 by plain 7-bit overflow.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
        return addr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// rtl/spi_reg_bridge_if.sv - byte stream and register bus bundle for spi_reg_bridge
interface spi_reg_bridge_if
    import spi_reg_pkg::*;
#(
    parameter int DATA_BYTES = 4
) ();

    logic                    i_RX_DV;
    logic [7:0]              i_RX_Byte;
    logic [7:0]              o_TX_Byte;
    logic [ADDR_W-1:0]       o_Addr;
    logic                    o_Wr_En;
    logic [8*DATA_BYTES-1:0] o_Wr_Data;
    logic                    o_Rd_Req;
    logic [8*DATA_BYTES-1:0] i_Rd_Data;
    logic                    i_Rd_Valid;
    logic                    o_Frame_Err;
    logic                    o_Busy;

    // Bridge side: consumes SPI bytes and read data, produces register strobes.
    modport slave (
        input  i_RX_DV, i_RX_Byte, i_Rd_Data, i_Rd_Valid,
        output o_TX_Byte, o_Addr, o_Wr_En, o_Wr_Data, o_Rd_Req, o_Frame_Err, o_Busy
    );

    // Environment side: SPI byte slave plus register file.
    modport master (
        output i_RX_DV, i_RX_Byte, i_Rd_Data, i_Rd_Valid,
        input  o_TX_Byte, o_Addr, o_Wr_En, o_Wr_Data, o_Rd_Req, o_Frame_Err, o_Busy
    );

endinterface

// File: rtl/spi_cs_sync.sv
// rtl/spi_cs_sync.sv - chip-select synchronizer with edge pulses
module spi_cs_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_pin,
    output logic cs_level,
    output logic cs_rise,
    output logic cs_fall
);

    logic sync1;
    logic sync2;
    logic prev;

    // Two-flop synchronizer followed by an edge-detect flop; all idle high (CS deasserted).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= cs_pin;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign cs_level = sync2;
    assign cs_rise  = sync2 & ~prev;
    assign cs_fall  = ~sync2 & prev;

endmodule

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI command decoder and register-bus bridge
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int         DATA_BYTES  = 4,
    parameter logic [7:0] STATUS_BYTE = DEF_STATUS_BYTE,
    parameter logic [7:0] IDLE_FILL   = DEF_IDLE_FILL
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_SPI_CS,
    spi_reg_bridge_if.slave   bus
);

    localparam int W  = 8 * DATA_BYTES;
    localparam int CW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_BYTES - 1);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] WR_DATA = ST_WR_DATA;
    localparam logic [1:0] RD_TURN = ST_RD_TURN;
    localparam logic [1:0] RD_DATA = ST_RD_DATA;

    logic cs_level;
    logic cs_rise;
    logic cs_fall;

    spi_cs_sync u_cs_sync (
        .clk      (i_Clk),
        .rst_n    (i_Rst_L),
        .cs_pin   (i_SPI_CS),
        .cs_level (cs_level),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall)
    );

    logic [1:0]        state,    state_n;
    logic [ADDR_W-1:0] addr,     addr_n;
    logic [CW-1:0]     cnt,      cnt_n;
    logic [W-1:0]      acc,      acc_n;
    logic [W-1:0]      wr_data,  wr_data_n;
    logic              wr_en,    wr_en_n;
    logic              rd_req,   rd_req_n;
    logic              err,      err_n;
    logic [7:0]        tx_byte,  tx_byte_n;
    logic [W-1:0]      tx_word,  tx_word_n;
    logic [W-1:0]      pf_data,  pf_data_n;
    logic              pf_valid, pf_valid_n;
    logic              xfer;
    logic              reading;

    // Next-state decode: byte handling first, then frame edges override so a byte
    // landing on the frame-end cycle still completes its write.
    always_comb begin
        state_n    = state;
        addr_n     = addr;
        cnt_n      = cnt;
        acc_n      = acc;
        wr_data_n  = wr_data;
        wr_en_n    = 1'b0;
        rd_req_n   = 1'b0;
        err_n      = 1'b0;
        tx_byte_n  = tx_byte;
        tx_word_n  = tx_word;
        pf_data_n  = pf_data;
        pf_valid_n = pf_valid;
        xfer       = 1'b0;
        reading    = (state == RD_TURN) || (state == RD_DATA);

        // The write strobe is presented with the word's own address; step afterwards.
        if (wr_en) begin
            addr_n = next_addr(addr);
        end

        // Read data is only captured while a read frame is open; late returns are dropped.
        if (bus.i_Rd_Valid && reading) begin
            pf_data_n  = bus.i_Rd_Data;
            pf_valid_n = 1'b1;
        end

        if (bus.i_RX_DV) begin
            case (state)
                IDLE: begin
                    addr_n     = bus.i_RX_Byte[ADDR_W-1:0];
                    cnt_n      = '0;
                    tx_byte_n  = IDLE_FILL;
                    pf_valid_n = 1'b0;
                    if (bus.i_RX_Byte[CMD_RD_BIT]) begin
                        state_n  = RD_TURN;
                        rd_req_n = 1'b1;
                    end else begin
                        state_n  = WR_DATA;
                    end
                end
                WR_DATA: begin
                    acc_n = (acc << 8) | W'(bus.i_RX_Byte);
                    if (cnt == LAST) begin
                        wr_en_n   = 1'b1;
                        wr_data_n = acc_n;
                        cnt_n     = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                RD_TURN: begin
                    xfer    = 1'b1;
                    state_n = RD_DATA;
                    cnt_n   = '0;
                end
                RD_DATA: begin
                    if (cnt == LAST) begin
                        xfer  = 1'b1;
                        cnt_n = '0;
                    end else begin
                        cnt_n     = cnt + CW'(1);
                        tx_word_n = tx_word << 8;
                        tx_byte_n = tx_word_n[W-1 -: 8];
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // Transfer point: move the prefetched word (or a same-cycle return) into
        // the shift register and request the following address.
        if (xfer) begin
            if (bus.i_Rd_Valid) begin
                tx_word_n = bus.i_Rd_Data;
            end else if (pf_valid) begin
                tx_word_n = pf_data;
            end else begin
                tx_word_n = {DATA_BYTES{IDLE_FILL}};
                err_n     = 1'b1;
            end
            tx_byte_n  = tx_word_n[W-1 -: 8];
            pf_valid_n = 1'b0;
            addr_n     = next_addr(addr);
            rd_req_n   = 1'b1;
        end

        // Either CS edge closes whatever was open; a half-built write word is an error.
        if (cs_rise || cs_fall) begin
            if ((state_n == WR_DATA) && (cnt_n != '0)) begin
                err_n = 1'b1;
            end
            state_n    = IDLE;
            cnt_n      = '0;
            pf_valid_n = 1'b0;
            rd_req_n   = 1'b0;
            tx_byte_n  = STATUS_BYTE;
        end
    end

    // State and output registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state    <= IDLE;
            addr     <= '0;
            cnt      <= '0;
            acc      <= '0;
            wr_data  <= '0;
            wr_en    <= 1'b0;
            rd_req   <= 1'b0;
            err      <= 1'b0;
            tx_byte  <= STATUS_BYTE;
            tx_word  <= '0;
            pf_data  <= '0;
            pf_valid <= 1'b0;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            cnt      <= cnt_n;
            acc      <= acc_n;
            wr_data  <= wr_data_n;
            wr_en    <= wr_en_n;
            rd_req   <= rd_req_n;
            err      <= err_n;
            tx_byte  <= tx_byte_n;
            tx_word  <= tx_word_n;
            pf_data  <= pf_data_n;
            pf_valid <= pf_valid_n;
        end
    end

    assign bus.o_TX_Byte   = tx_byte;
    assign bus.o_Addr      = addr;
    assign bus.o_Wr_En     = wr_en;
    assign bus.o_Wr_Data   = wr_data;
    assign bus.o_Rd_Req    = rd_req;
    assign bus.o_Frame_Err = err;
    assign bus.o_Busy      = ~cs_level;

endmodule
